// File: rtl/muldiv_unit_pkg.sv
// Shared RV32M definitions for the iterative multiply/divide unit:
// funct3 encodings, M-instruction decode match and the FSM state type.
package muldiv_unit_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  // True for an R-type instruction that belongs to the M extension.
  function automatic logic is_m_instr(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == OPC_OP) && (funct7 == F7_MULDIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits, and report the quotient bit.
module div_step (
  input  logic [32:0] rem_i,
  input  logic        dvd_bit_i,
  input  logic [31:0] divisor_i,
  output logic [32:0] rem_o,
  output logic        q_o
);

  logic [32:0] trial;

  always_comb begin
    trial = {rem_i[31:0], dvd_bit_i};
    q_o   = ({rem_i, dvd_bit_i} >= {2'b00, divisor_i});
    if (q_o) begin
      rem_o = trial - {1'b0, divisor_i};
    end else begin
      rem_o = trial;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: magnitude datapath (32-cycle shift-add
// multiply, 32-cycle restoring divide) with a sign fixup on the way out.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  muldiv_state_t state_q, state_d;
  logic [2:0]         f3_q, f3_d;
  logic               neg_q, neg_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               a_signed, b_signed, sign_a, sign_b, neg_sel;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               div_by_zero, div_ovf;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_rem;
  logic               div_q;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, word;

  div_step u_div_step (
    .rem_i     (rem_q),
    .dvd_bit_i (quo_q[WIDTH-1]),
    .divisor_i (opnd_q),
    .rem_o     (div_rem),
    .q_o       (div_q)
  );

  // Operand preparation: MULHSU keeps op_b unsigned, MULHU/DIVU/REMU are fully unsigned.
  always_comb begin
    a_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
               (funct3 == F3_DIV) || (funct3 == F3_REM);
    b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
               (funct3 == F3_DIV) || (funct3 == F3_REM);
    sign_a   = a_signed & op_a[WIDTH-1];
    sign_b   = b_signed & op_b[WIDTH-1];
    abs_a    = sign_a ? ({WIDTH{1'b0}} - op_a) : op_a;
    abs_b    = sign_b ? ({WIDTH{1'b0}} - op_b) : op_b;
    case (funct3)
      F3_MUL, F3_MULH, F3_DIV: neg_sel = sign_a ^ sign_b;
      F3_MULHSU, F3_REM:       neg_sel = sign_a;
      default:                 neg_sel = 1'b0;
    endcase
    div_by_zero = (op_b == {WIDTH{1'b0}});
    div_ovf     = !funct3[0] && (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b == {WIDTH{1'b1}});
  end

  // Datapath steps and output fixup: the product is negated as 64 bits before word selection.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    prod_fix = neg_q ? ({(2*WIDTH){1'b0}} - acc_q) : acc_q;
    quo_fix  = neg_q ? ({WIDTH{1'b0}} - quo_q) : quo_q;
    rem_fix  = neg_q ? ({WIDTH{1'b0}} - rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
    case (f3_q)
      F3_MUL:                       word = prod_fix[WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: word = prod_fix[2*WIDTH-1:WIDTH];
      F3_DIV, F3_DIVU:              word = quo_fix;
      default:                      word = rem_fix;
    endcase
  end

  // Next-state logic for the IDLE/CALC/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          f3_d  = funct3;
          neg_d = neg_sel;
          cnt_d = 5'd0;
          if (funct3[2] && div_by_zero) begin
            quo_d   = {WIDTH{1'b1}};
            rem_d   = {1'b0, op_a};
            neg_d   = 1'b0;
            state_d = DONE;
          end else if (funct3[2] && div_ovf) begin
            quo_d   = {1'b1, {(WIDTH-1){1'b0}}};
            rem_d   = {(WIDTH+1){1'b0}};
            neg_d   = 1'b0;
            state_d = DONE;
          end else if (funct3[2]) begin
            quo_d   = abs_a;
            rem_d   = {(WIDTH+1){1'b0}};
            opnd_d  = abs_b;
            state_d = CALC;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, abs_b};
            opnd_d  = abs_a;
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (f3_q[2]) begin
          rem_d = div_rem;
          quo_d = {quo_q[WIDTH-2:0], div_q};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = DONE;
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        result_d = word;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == CALC);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      f3_q     <= 3'd0;
      neg_q    <= 1'b0;
      cnt_q    <= 5'd0;
      acc_q    <= {(2*WIDTH){1'b0}};
      opnd_q   <= {WIDTH{1'b0}};
      rem_q    <= {(WIDTH+1){1'b0}};
      quo_q    <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver queues hand-computed results,
// latencies and busy lengths; a monitor checks them on every done pulse.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    int          busy_n;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   busy_run = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: counts busy cycles and checks each done against the scoreboard head.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (busy) busy_run++;
    if (done) begin
      chk("busy_done_overlap", {31'b0, busy}, 32'd0);
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: got done with result %h, expected no done", result);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_result"}, result, e.res);
        chk({e.name, "_latency"}, cyc, e.cyc);
        chk({e.name, "_busy_cycles"}, busy_run, e.busy_n);
      end
      busy_run = 0;
    end
    if (reset) busy_run = 0;
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input bit sp, input bit push, input string nm);
    exp_t e;
    @(negedge clk);
    funct3 = f;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    if (push) begin
      e.res    = r;
      e.cyc    = cyc + (sp ? 2 : 34);
      e.busy_n = sp ? 0 : 32;
      e.name   = nm;
      sb.push_back(e);
    end
    @(negedge clk);
    start  = 1'b0;
    funct3 = 3'($urandom_range(7, 0));
    op_a   = $urandom;
    op_b   = $urandom;
  endtask

  task automatic wait_done(input string nm);
    bit seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    n_chk++;
    if (seen) n_pass++;
    else $display("FAIL %s_timeout: got no done, expected done within 60 cycles", nm);
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] r, input bit sp, input string nm);
    issue(f, a, b, r, sp, 1'b1, nm);
    wait_done(nm);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    funct3 = 3'd0;
    op_a   = 32'd0;
    op_b   = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);

    // Directed vectors; every op is issued the cycle after the previous done.
    run(F3_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, "mul_7x-3");
    run(F3_MULH,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, "mulh");
    run(F3_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, "mulhsu");
    run(F3_MULHU,  32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b0, "mulhu");
    run(F3_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, "div_-7/2");
    run(F3_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, "rem_-7/2");
    run(F3_DIVU,   32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 1'b0, "divu");
    run(F3_REMU,   32'hFFFFFFF9, 32'h00000002, 32'h00000001, 1'b0, "remu");
    run(F3_DIV,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 1'b0, "div_-7/-2");
    run(F3_REM,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, "rem_-7/-2");
    run(F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, "mulhu_max");
    run(F3_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, "divu_no_ovf");
    run(F3_DIV,    32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b1, "div_by_0");
    run(F3_REM,    32'h00000005, 32'h00000000, 32'h00000005, 1'b1, "rem_by_0");
    run(F3_REMU,   32'h00000009, 32'h00000000, 32'h00000009, 1'b1, "remu_by_0");
    run(F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "div_ovf");
    run(F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, "rem_ovf");

    // A start pulse while busy must neither disturb nor queue behind the running op.
    issue(F3_MUL, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 1'b1, "mul_ignore_start");
    repeat (5) @(negedge clk);
    funct3 = F3_DIV;
    op_a   = 32'h00000005;
    op_b   = 32'h00000000;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("mul_ignore_start");

    // Reset at counter 15 abandons the op: no done, cleared result, idle again.
    issue(F3_DIVU, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0, "divu_abandoned");
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midcalc_reset_busy", {31'b0, busy}, 32'd0);
    chk("midcalc_reset_done", {31'b0, done}, 32'd0);
    chk("midcalc_reset_result", result, 32'd0);
    repeat (40) @(negedge clk);

    run(F3_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, "divu_after_reset");
    run(F3_REMU, 32'd100, 32'd7, 32'd2, 1'b0, "remu_b2b");
    run(F3_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, "mul_-1x-1");

    repeat (3) @(negedge clk);
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_leftover: got %0d pending entries, expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, beside the ALU. It accepts one M-extension operation per start pulse and holds the pipeline via `busy` while it runs. It returns a 32-bit result that the execute stage forwards as its `ALU_out_EXMEM` value to the memory/writeback stage. One operation is in flight at a time; results are computed on operand magnitudes with a final sign fixup.

## Interface
- `WIDTH`, 32: operand and result width in bits. Must stay 32.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request a new operation. Sampled only in IDLE.
- `funct3` input 3: operation select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a` input WIDTH: rs1 data (dividend or multiplicand).
- `op_b` input WIDTH: rs2 data (divisor or multiplier).
- `busy` output 1: high in CALC. The execute stage stalls IF/ID/EX on `busy | (start & idle)`.
- `done` output 1: one-cycle pulse; `result` is valid in this cycle.
- `result` output WIDTH: registered result. It holds its value until the next `done`.

## Operation
- States are IDLE, CALC and DONE. Reset forces IDLE, `busy=0`, `done=0`, `result=0`, and the iteration counter to 0.
- IDLE, when `start=1`:
  - latch `funct3`;
  - form the magnitudes `|a|` and `|b|`;
  - latch `neg_res`:
    - MUL/MULH: sign(a)^sign(b);
    - MULHSU: sign(a);
    - DIV: sign(a)^sign(b);
    - REM: sign(a);
    - unsigned ops: 0.
  - MULHSU treats `op_b` as unsigned. MUL uses the signed path; its low word is sign-agnostic.
- Special cases skip CALC and go directly IDLE→DONE:
  - divide by zero (`op_b=0`, any DIV/REM): quotient 0xFFFFFFFF, remainder = `op_a`;
  - signed overflow (DIV/REM with `op_a=0x80000000`, `op_b=0xFFFFFFFF`): quotient 0x80000000, remainder 0.
- All other operations go IDLE→CALC with counter=0.
- CALC, multiply:
  - radix-2 shift-add into a 64-bit accumulator, one multiplier bit per cycle, LSB first;
  - 32 iterations, counter 0..31; leaves for DONE when counter=31.
- CALC, divide:
  - restoring division;
  - 33-bit partial remainder, one quotient bit per cycle, MSB first;
  - 32 iterations.
- DONE:
  - apply two's-complement negation when `neg_res=1`; MUL/MULH negate the full 64-bit product before word selection;
  - select the word: MUL takes the low word, MULH* the high word, DIV* the quotient, REM* the remainder;
  - register the word into `result`, pulse `done`, return to IDLE.
- `start` during CALC or DONE is ignored and not queued.
- All arithmetic is modulo 2^32 or 2^64; no overflow flags.

## Timing
- `start` is sampled at edge E0.
- Normal operation:
  - CALC occupies the cycles after edges E0..E31;
  - DONE is entered at E32;
  - `result` is registered and `done=1` in the cycle after E33, i.e. latency 34 edges.
- Special case: `done=1` in the cycle after E1 (latency 2).
- `busy` is high from the cycle after E0 until the last CALC cycle inclusive. `busy` and `done` are never high together.
- A back-to-back `start` is accepted at the first IDLE cycle after `done`.
- Reset asserted mid-CALC: the operation is abandoned, there is no `done`, and the unit is in IDLE the cycle after reset.
- Reset takes priority over `start` in the same cycle.
- Inputs need only be stable at E0. They are latched and may change afterwards.

## Structure
- Shared definitions file:
  - the M-extension `funct3` constants (`F3_MUL` .. `F3_REMU`);
  - the opcode/funct7 match for M instructions (funct7=0000001);
  - the state enum `muldiv_state_t` {IDLE, CALC, DONE}.
- One natural sub-module, `div_step`: a combinational restoring step.
  - Inputs: 33-bit partial remainder, next dividend bit, divisor.
  - Outputs: new remainder and quotient bit.
- The multiply step, the sign preparation and the fixup stay inline.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD) → `done` 34 edges after `start`, `result` 0xFFFFFFEB; `busy` high exactly 32 cycles.
- MULH / MULHSU / MULHU with 0x80000000 × 0xFFFFFFFF → MULH 0x00000000, MULHSU 0x80000000, MULHU 0x7FFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC; REMU → 1.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF, REM 5/0 → 5, `done` 2 edges after `start`, `busy` never high. Overflow: DIV 0x80000000/−1 → 0x80000000, REM → 0.
- Robustness:
  - `start` pulsed during CALC is ignored;
  - reset at counter=15 gives no `done`, `result=0`, IDLE next cycle;
  - a new `start` the cycle after `done` is accepted and completes correctly.
